calc_op_sequencer: RTL and testbench

CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

---
 rtl/calc_op_sequencer.sv | 163 ++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Fetches two operands (D1 from address A, D2 from address B) from a
// fixed-latency operand memory. It then presents them to the ALU stage
// together with the opcode that was latched when the request was accepted.
//
// Optional feature macro: CALC_SEQ_OPCHK_EN
//   defined   - a non-one-hot opcode at an accepted start skips both reads.
//               The block goes straight to DONE with oERR=1 and oVALID=1.
//   undefined - oERR stays 0 and every opcode is fetched and passed through.
//
// The memory read latency RD_LAT must be in the range 1..4.
module calc_op_sequencer #(
    parameter int AW     = 4,
    parameter int DW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          iCLK,
    input  logic          nRST,
    input  logic          iSTART,
    input  logic [AW-1:0] iADDR_A,
    input  logic [AW-1:0] iADDR_B,
    input  logic [2:0]    iOPCODE,
    input  logic          iACK,
    input  logic [DW-1:0] iMEM_D,
    output logic [AW-1:0] oMEM_A,
    output logic          oMEM_RD,
    output logic [DW-1:0] oD1,
    output logic [DW-1:0] oD2,
    output logic [2:0]    oOPCODE,
    output logic          oVALID,
    output logic          oBUSY,
    output logic          oERR
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        WAIT_A = 3'd2,
        RD_B   = 3'd3,
        WAIT_B = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Value the wait counter holds on the final wait cycle, when read data is valid.
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t        state;
    logic [2:0]    lat_cnt;
    logic [AW-1:0] addr_b;
    logic          accept;
    logic          op_reject;

    // A new request is taken from IDLE, or from DONE in the same cycle the
    // current result is acknowledged.
    // At every other point iSTART is ignored.
    always_comb begin
        accept = iSTART && ((state == IDLE) || ((state == DONE) && iACK));
    end

`ifdef CALC_SEQ_OPCHK_EN
    // Flag any opcode that is not exactly one of add/sub/mul.
    always_comb begin
        op_reject = !((iOPCODE == 3'b001) || (iOPCODE == 3'b010) || (iOPCODE == 3'b100));
    end
`else
    // Opcode checking is disabled: every opcode is fetched normally.
    always_comb begin
        op_reject = 1'b0;
    end
`endif

    // The sequencer FSM.
    // Every output is registered here, so each output changes only on the
    // same edge as the state change that implies it.
    // The address for operand A goes straight to oMEM_A at acceptance, so
    // only B has to be kept for later.
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            addr_b  <= '0;
            oMEM_A  <= '0;
            oMEM_RD <= 1'b0;
            oD1     <= '0;
            oD2     <= '0;
            oOPCODE <= 3'b000;
            oVALID  <= 1'b0;
            oBUSY   <= 1'b0;
            oERR    <= 1'b0;
        end else if (accept) begin
            addr_b  <= iADDR_B;
            oOPCODE <= iOPCODE;
            oBUSY   <= 1'b1;
            lat_cnt <= 3'd0;
            if (op_reject) begin
                state   <= DONE;
                oMEM_RD <= 1'b0;
                oVALID  <= 1'b1;
                oERR    <= 1'b1;
            end else begin
                state   <= RD_A;
                oMEM_RD <= 1'b1;
                oMEM_A  <= iADDR_A;
                oVALID  <= 1'b0;
                oERR    <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    oBUSY <= 1'b0;
                end
                RD_A: begin
                    oMEM_RD <= 1'b0;
                    lat_cnt <= 3'd0;
                    state   <= WAIT_A;
                end
                WAIT_A: begin
                    if (lat_cnt == LAT_LAST) begin
                        oD1     <= iMEM_D;
                        lat_cnt <= 3'd0;
                        oMEM_RD <= 1'b1;
                        oMEM_A  <= addr_b;
                        state   <= RD_B;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                RD_B: begin
                    oMEM_RD <= 1'b0;
                    lat_cnt <= 3'd0;
                    state   <= WAIT_B;
                end
                WAIT_B: begin
                    if (lat_cnt == LAT_LAST) begin
                        oD2     <= iMEM_D;
                        lat_cnt <= 3'd0;
                        oVALID  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (iACK) begin
                        oVALID <= 1'b0;
                        oERR   <= 1'b0;
                        oBUSY  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    oMEM_RD <= 1'b0;
                    oVALID  <= 1'b0;
                    oERR    <= 1'b0;
                    oBUSY   <= 1'b0;
                    lat_cnt <= 3'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer.
// Two instances are driven: one with RD_LAT=1 and one with RD_LAT=3.
// Each instance reads from its own operand memory model. The model returns
// valid data only in the final latency cycle; in every other cycle it
// returns the bitwise inverse of the correct data.
// Expected behaviour is worked out from the request schedule:
//   - read A, then read B, one read strobe each
//   - result valid 2*RD_LAT+2 cycles after the start is accepted
//   - operands equal to the memory contents at the requested addresses
module tb_calc_op_sequencer;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          iCLK = 1'b0;
    logic          nRST;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [2:0]    opcode;
    logic          start1;
    logic          ack1;
    logic          start3;
    logic          ack3;

    logic [DW-1:0] memD1;
    logic [DW-1:0] memD3;
    logic [AW-1:0] memA1;
    logic [AW-1:0] memA3;
    logic          memRd1;
    logic          memRd3;
    logic [DW-1:0] outD1_1;
    logic [DW-1:0] outD2_1;
    logic [DW-1:0] outD1_3;
    logic [DW-1:0] outD2_3;
    logic [2:0]    opc1;
    logic [2:0]    opc3;
    logic          valid1;
    logic          valid3;
    logic          busy1;
    logic          busy3;
    logic          err1;
    logic          err3;

    logic [DW-1:0] mem [16];
    logic          pv1;
    logic [AW-1:0] pa1;
    logic [2:0]    pv3;
    logic [AW-1:0] pa3 [3];

    bit            useD3 = 1'b0;
    logic          obsRd;
    logic [AW-1:0] obsMemA;
    logic [DW-1:0] obsD1;
    logic [DW-1:0] obsD2;
    logic [2:0]    obsOpc;
    logic          obsValid;
    logic          obsBusy;
    logic          obsErr;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] lastD1 = '0;
    logic [DW-1:0] lastD2 = '0;

    // Free-running clock with a 10-time-unit period.
    always #5 iCLK = ~iCLK;

    calc_op_sequencer #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (
        .iCLK(iCLK), .nRST(nRST), .iSTART(start1), .iADDR_A(addrA), .iADDR_B(addrB),
        .iOPCODE(opcode), .iACK(ack1), .iMEM_D(memD1), .oMEM_A(memA1), .oMEM_RD(memRd1),
        .oD1(outD1_1), .oD2(outD2_1), .oOPCODE(opc1), .oVALID(valid1), .oBUSY(busy1), .oERR(err1)
    );

    calc_op_sequencer #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
        .iCLK(iCLK), .nRST(nRST), .iSTART(start3), .iADDR_A(addrA), .iADDR_B(addrB),
        .iOPCODE(opcode), .iACK(ack3), .iMEM_D(memD3), .oMEM_A(memA3), .oMEM_RD(memRd3),
        .oD1(outD1_3), .oD2(outD2_3), .oOPCODE(opc3), .oVALID(valid3), .oBUSY(busy3), .oERR(err3)
    );

    // Memory read pipelines.
    // A read strobed at edge k returns data between edge k+RD_LAT-1 and edge k+RD_LAT.
    always @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            pv1    <= 1'b0;
            pa1    <= '0;
            pv3    <= 3'b000;
            pa3[0] <= '0;
            pa3[1] <= '0;
            pa3[2] <= '0;
        end else begin
            pv1    <= memRd1;
            pa1    <= memA1;
            pv3    <= {pv3[1:0], memRd3};
            pa3[0] <= memA3;
            pa3[1] <= pa3[0];
            pa3[2] <= pa3[1];
        end
    end

    // Memory returns valid data only in the valid window and the inverse of the right data otherwise.
    always_comb begin
        memD1 = pv1    ? mem[pa1]    : ~mem[memA1];
        memD3 = pv3[2] ? mem[pa3[2]] : ~mem[memA3];
    end

    // Route the outputs of the instance currently under test to one observation point.
    always_comb begin
        obsRd    = useD3 ? memRd3  : memRd1;
        obsMemA  = useD3 ? memA3   : memA1;
        obsD1    = useD3 ? outD1_3 : outD1_1;
        obsD2    = useD3 ? outD2_3 : outD2_1;
        obsOpc   = useD3 ? opc3    : opc1;
        obsValid = useD3 ? valid3  : valid1;
        obsBusy  = useD3 ? busy3   : busy1;
        obsErr   = useD3 ? err3    : err1;
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setCtl(input logic s, input logic a);
        if (useD3) begin
            start3 = s;
            ack3   = a;
            start1 = 1'b0;
            ack1   = 1'b0;
        end else begin
            start1 = s;
            ack1   = a;
            start3 = 1'b0;
            ack3   = 1'b0;
        end
    endtask

    task automatic randomizeMem();
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic scrambleInputs();
        addrA  = 4'($urandom_range(0, 15));
        addrB  = 4'($urandom_range(0, 15));
        opcode = 3'($urandom_range(0, 7));
    endtask

    // Issue one request and follow it cycle by cycle until the result is valid.
    // Then hold the result for 'hold' cycles without an acknowledge.
    // The request is raised together with ack, so acceptance works both from
    // IDLE and from DONE.
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic [2:0] op, input int hold);
        int rl;
        int last;
        logic [DW-1:0] expD1;
        logic [DW-1:0] expD2;
        rl    = useD3 ? 3 : 1;
        last  = 2 * rl + 2;
        expD1 = mem[a];
        expD2 = mem[b];
        addrA  = a;
        addrB  = b;
        opcode = op;
        setCtl(1'b1, 1'b1);
        for (int k = 0; k <= last; k++) begin
            tick();
            checkOutput("rd_strobe", obsRd, (k == 0 || k == rl + 1));
            checkOutput("mem_addr", obsMemA, (k <= rl) ? a : b);
            checkOutput("valid_timing", obsValid, k == last);
            checkOutput("busy", obsBusy, 1);
            checkOutput("err", obsErr, 0);
            checkOutput("opcode", obsOpc, op);
            if (k >= rl + 1) checkOutput("d1_capture", obsD1, expD1);
            if (k == last) checkOutput("d2_capture", obsD2, expD2);
            if (k < last) begin
                scrambleInputs();
                setCtl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        for (int h = 0; h < hold; h++) begin
            scrambleInputs();
            setCtl(1'($urandom_range(0, 1)), 1'b0);
            tick();
            checkOutput("hold_valid", obsValid, 1);
            checkOutput("hold_rd", obsRd, 0);
            checkOutput("hold_d1", obsD1, expD1);
            checkOutput("hold_d2", obsD2, expD2);
            checkOutput("hold_opcode", obsOpc, op);
            checkOutput("hold_addr", obsMemA, b);
        end
        setCtl(1'b0, 1'b0);
        lastD1 = expD1;
        lastD2 = expD2;
    endtask

    // Acknowledge the result and confirm a return to an idle sequencer.
    // An acknowledge seen while idle must have no effect.
    task automatic releaseToIdle();
        setCtl(1'b0, 1'b1);
        tick();
        checkOutput("ack_valid", obsValid, 0);
        checkOutput("ack_busy", obsBusy, 0);
        checkOutput("ack_err", obsErr, 0);
        checkOutput("ack_rd", obsRd, 0);
        tick();
        checkOutput("idle_busy", obsBusy, 0);
        checkOutput("idle_d1", obsD1, lastD1);
        checkOutput("idle_d2", obsD2, lastD2);
        setCtl(1'b0, 1'b0);
    endtask

    // Directed sequence first, then randomized requests.
    initial begin
        logic [2:0] op;
        nRST   = 1'b1;
        addrA  = '0;
        addrB  = '0;
        opcode = 3'b000;
        start1 = 1'b0;
        ack1   = 1'b0;
        start3 = 1'b0;
        ack3   = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1 nRST = 1'b0;
        #12;
        checkOutput("rst_mem_addr", memA1, 0);
        checkOutput("rst_rd", memRd1, 0);
        checkOutput("rst_d1", outD1_1, 0);
        checkOutput("rst_d2", outD2_1, 0);
        checkOutput("rst_opcode", opc1, 0);
        checkOutput("rst_valid", valid1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_err", err1, 0);
        checkOutput("rst3_valid", valid3, 0);
        checkOutput("rst3_busy", busy3, 0);
        tick();
        nRST = 1'b1;
        tick();

        // Basic fetch with known memory contents, then a long hold in DONE.
        useD3 = 1'b0;
        randomizeMem();
        mem[3] = 4'd5;
        mem[7] = 4'd9;
        applyStimulus(4'd3, 4'd7, 3'b001, 10);
        releaseToIdle();

        // Back-to-back request accepted in the same cycle as the acknowledge.
        randomizeMem();
        applyStimulus(4'd5, 4'd9, 3'b100, 1);
        applyStimulus(4'd0, 4'd15, 3'b010, 2);
        releaseToIdle();

        // Randomized legal requests.
        for (int t = 0; t < 16; t++) begin
            randomizeMem();
            op = 3'b001 << $urandom_range(0, 2);
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), op,
                          int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) releaseToIdle();
        end
        releaseToIdle();

        // Opcode outside the one-hot set.
`ifdef CALC_SEQ_OPCHK_EN
        scrambleInputs();
        opcode = 3'b011;
        setCtl(1'b1, 1'b0);
        tick();
        checkOutput("bad_op_rd", obsRd, 0);
        checkOutput("bad_op_valid", obsValid, 1);
        checkOutput("bad_op_err", obsErr, 1);
        checkOutput("bad_op_busy", obsBusy, 1);
        checkOutput("bad_op_d1", obsD1, lastD1);
        checkOutput("bad_op_d2", obsD2, lastD2);
        checkOutput("bad_op_opcode", obsOpc, 3'b011);
        setCtl(1'b0, 1'b0);
        tick();
        checkOutput("bad_op_hold_rd", obsRd, 0);
        checkOutput("bad_op_hold_err", obsErr, 1);
        releaseToIdle();
`else
        randomizeMem();
        applyStimulus(4'd2, 4'd11, 3'b011, 1);
        releaseToIdle();
`endif

        // Reset asserted while the second operand is outstanding.
        randomizeMem();
        addrA  = 4'd6;
        addrB  = 4'd12;
        opcode = 3'b001;
        setCtl(1'b1, 1'b0);
        tick();
        setCtl(1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("pre_reset_busy", obsBusy, 1);
        checkOutput("pre_reset_d1", obsD1, mem[6]);
        #2 nRST = 1'b0;
        #1;
        checkOutput("mid_rst_mem_addr", memA1, 0);
        checkOutput("mid_rst_rd", memRd1, 0);
        checkOutput("mid_rst_d1", outD1_1, 0);
        checkOutput("mid_rst_d2", outD2_1, 0);
        checkOutput("mid_rst_opcode", opc1, 0);
        checkOutput("mid_rst_valid", valid1, 0);
        checkOutput("mid_rst_busy", busy1, 0);
        checkOutput("mid_rst_err", err1, 0);
        tick();
        tick();
        nRST = 1'b1;
        lastD1 = '0;
        lastD2 = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("post_rst_rd", obsRd, 0);
            checkOutput("post_rst_busy", obsBusy, 0);
            checkOutput("post_rst_valid", obsValid, 0);
        end

        // Longer memory latency on the second instance.
        useD3 = 1'b1;
        randomizeMem();
        applyStimulus(4'd1, 4'd14, 3'b001, 2);
        releaseToIdle();
        randomizeMem();
        applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'b100, 1);
        applyStimulus(4'd15, 4'd0, 3'b010, 0);
        releaseToIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
